// File: rtl/param_add_accum.sv
// Two-stage pipelined add/sub/accumulate/clear unit with overflow reporting,
// optional accumulator saturation and a wrapping completed-result counter.
module param_add_accum #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 ovf,
  output logic                 ovf_sticky,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 clk_out
);

  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpAcc = 2'b10, OpClr = 2'b11} op_e;

  logic                 r_v1;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  op_e                  r_op;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_out;
  logic                 r_ovf;
  logic                 r_sticky;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [ACC_WIDTH-1:0] w_a_ext;
  logic [ACC_WIDTH-1:0] w_b_ext;
  logic [SumWidth-1:0]  w_sum;
  logic [ACC_WIDTH-1:0] w_res;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic                 w_sticky_nxt;

  assign w_a_ext = ACC_WIDTH'(r_a);
  assign w_b_ext = ACC_WIDTH'(r_b);
  assign w_sum   = SumWidth'(r_acc) + SumWidth'(r_a) + SumWidth'(r_b);

  always_comb begin
    w_res        = '0;
    w_ovf        = 1'b0;
    w_acc_nxt    = r_acc;
    w_sticky_nxt = r_sticky;
    unique case (r_op)
      OpAdd: w_res = w_a_ext + w_b_ext;
      OpSub: begin
        w_res = w_a_ext - w_b_ext;
        w_ovf = (r_a < r_b);
      end
      OpAcc: begin
        w_ovf = w_sum[ACC_WIDTH];
        // Clamp only in saturating builds; the flag still reports the raw carry.
        if (w_ovf && (SATURATE != 0)) begin
          w_res = '1;
        end else begin
          w_res = w_sum[ACC_WIDTH-1:0];
        end
        w_acc_nxt = w_res;
      end
      OpClr: begin
        w_res     = '0;
        w_acc_nxt = '0;
      end
      default: w_res = '0;
    endcase
    w_sticky_nxt = (r_op == OpClr) ? 1'b0 : (r_sticky | w_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OpAdd;
      r_acc       <= '0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_v1        <= in_valid;
      r_out_valid <= r_v1;
      if (in_valid) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op_e'(op);
      end
      if (r_v1) begin
        r_out    <= w_res;
        r_ovf    <= w_ovf;
        r_acc    <= w_acc_nxt;
        r_sticky <= w_sticky_nxt;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out        = r_out;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;
  assign op_count   = r_cnt;
  assign clk_out    = clk;

endmodule

// File: tb/tb_param_add_accum.sv
// Bench for param_add_accum: three parameter variants share one stimulus stream and are
// compared against an in-order transaction model applied when each result is due.
module tb_param_add_accum;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAcc = 2'b10;
  localparam logic [1:0] OpClr = 2'b11;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;

  logic       ov   [3];
  logic [7:0] res  [3];
  logic       ovf  [3];
  logic       stk  [3];
  logic       clko [3];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  param_add_accum #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(0), .CNT_WIDTH(8)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(ov[0]), .out(res[0]), .ovf(ovf[0]), .ovf_sticky(stk[0]),
    .op_count(cnt0), .clk_out(clko[0])
  );
  param_add_accum #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(1), .CNT_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(ov[1]), .out(res[1]), .ovf(ovf[1]), .ovf_sticky(stk[1]),
    .op_count(cnt1), .clk_out(clko[1])
  );
  param_add_accum #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(0), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(ov[2]), .out(res[2]), .ovf(ovf[2]), .ovf_sticky(stk[2]),
    .op_count(cnt2), .clk_out(clko[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int op;
    int a;
    int b;
  } txn_t;

  txn_t q[$];
  int   cyc;
  int   checks;
  int   errors;
  bit   exp_valid;
  int   sat_p [3] = '{0, 1, 0};
  int   cw_p  [3] = '{8, 8, 2};
  int   m_acc [3];
  int   m_out [3];
  int   m_ovf [3];
  int   m_stk [3];
  int   m_cnt [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Architectural effect of one completed operation on variant k.
  task automatic apply(input int k, input int o, input int xa, input int xb);
    int s;
    case (o)
      0: begin m_out[k] = xa + xb; m_ovf[k] = 0; end
      1: begin m_out[k] = (xa - xb + 256) % 256; m_ovf[k] = (xa < xb) ? 1 : 0; end
      2: begin
        s = m_acc[k] + xa + xb;
        m_ovf[k] = (s > 255) ? 1 : 0;
        m_out[k] = (m_ovf[k] == 1 && sat_p[k] == 1) ? 255 : s % 256;
        m_acc[k] = m_out[k];
      end
      default: begin m_out[k] = 0; m_ovf[k] = 0; m_acc[k] = 0; end
    endcase
    m_stk[k] = (o == 3) ? 0 : (m_stk[k] | m_ovf[k]);
    m_cnt[k] = (m_cnt[k] + 1) % (1 << cw_p[k]);
  endtask

  task automatic model_edge(input logic v, input logic [1:0] o, input logic [3:0] xa,
                            input logic [3:0] xb, input logic rst);
    txn_t t;
    exp_valid = 1'b0;
    if (rst) begin
      q.delete();
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_out[k] = 0; m_ovf[k] = 0; m_stk[k] = 0; m_cnt[k] = 0;
      end
      return;
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      t = q.pop_front();
      exp_valid = 1'b1;
      for (int k = 0; k < 3; k++) apply(k, t.op, t.a, t.b);
    end
    if (v) begin
      t.due = cyc + 1;
      t.op  = int'(o);
      t.a   = int'(xa);
      t.b   = int'(xb);
      q.push_back(t);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] o, input logic [3:0] xa,
                      input logic [3:0] xb, input logic rst);
    logic [31:0] cnt_got [3];
    in_valid = v;
    op       = o;
    a        = xa;
    b        = xb;
    reset    = rst;
    @(posedge clk);
    cyc++;
    model_edge(v, o, xa, xb, rst);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("clk_out_hi[%0d]", k), 32'(clko[k]), 32'd1);
    @(negedge clk);
    cnt_got[0] = 32'(cnt0);
    cnt_got[1] = 32'(cnt1);
    cnt_got[2] = 32'(cnt2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("clk_out_lo[%0d]", k), 32'(clko[k]), 32'd0);
      check($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(exp_valid));
      check($sformatf("out[%0d]", k), 32'(res[k]), 32'(m_out[k]));
      check($sformatf("ovf[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
      check($sformatf("ovf_sticky[%0d]", k), 32'(stk[k]), 32'(m_stk[k]));
      check($sformatf("op_count[%0d]", k), cnt_got[k], 32'(m_cnt[k]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, OpAdd, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    op       = OpAdd;
    a        = '0;
    b        = '0;
    @(negedge clk);

    step(1'b0, OpAdd, 4'd0, 4'd0, 1'b1);
    step(1'b0, OpAdd, 4'd0, 4'd0, 1'b1);

    step(1'b1, OpAdd, 4'd15, 4'd15, 1'b0);
    idle(3);

    step(1'b1, OpSub, 4'd3, 4'd5, 1'b0);
    step(1'b1, OpSub, 4'd5, 4'd3, 1'b0);
    idle(2);

    // Nine chained ACCs overflow on the ninth; a trailing ACC 0+0 shows the saturated case.
    step(1'b1, OpClr, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, OpAcc, 4'd15, 4'd15, 1'b0);
    step(1'b1, OpAcc, 4'd0, 4'd0, 1'b0);
    idle(2);

    step(1'b1, OpAcc, 4'd7, 4'd1, 1'b0);
    step(1'b0, OpAdd, 4'd0, 4'd0, 1'b1);
    idle(2);
    step(1'b1, OpAcc, 4'd1, 4'd1, 1'b0);
    idle(2);

    step(1'b0, OpAdd, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OpAdd, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      idle(1);
    end
    idle(2);

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 59) == 0));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
